// File: rtl/alu_ctrl_md_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_ctrl_md_seq_pkg
// Description : Shared encodings for the EX-stage ALU controller and its
//               RV32M multi-cycle sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_ctrl_md_seq_pkg;

    // Single-cycle ALU control encodings
    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLT  = 4'd5,
        ALU_SLTU = 4'd6,
        ALU_SLL  = 4'd7,
        ALU_SRL  = 4'd8,
        ALU_SRA  = 4'd9
    } alu_ctrl_e;

    // RV32M operations, indexed by func3
    typedef enum logic [2:0] {
        MD_MUL    = 3'b000,
        MD_MULH   = 3'b001,
        MD_MULHSU = 3'b010,
        MD_MULHU  = 3'b011,
        MD_DIV    = 3'b100,
        MD_DIVU   = 3'b101,
        MD_REM    = 3'b110,
        MD_REMU   = 3'b111
    } md_op_e;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } md_state_e;

    localparam logic [1:0] C_ALUOP_STORE  = 2'b00;
    localparam logic [1:0] C_ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] C_ALUOP_RTYPE  = 2'b10;
    localparam logic [1:0] C_ALUOP_ITYPE  = 2'b11;

    localparam logic [6:0] C_F7_ALT    = 7'b0100000;
    localparam logic [6:0] C_F7_MULDIV = 7'b0000001;

    // rs1 is treated as signed for MUL/MULH/MULHSU/DIV/REM
    function automatic logic md_a_signed(input logic [2:0] f3);
        return (f3 == MD_MUL) || (f3 == MD_MULH) || (f3 == MD_MULHSU) ||
               (f3 == MD_DIV) || (f3 == MD_REM);
    endfunction

    // rs2 is treated as signed for MUL/MULH/DIV/REM
    function automatic logic md_b_signed(input logic [2:0] f3);
        return (f3 == MD_MUL) || (f3 == MD_MULH) ||
               (f3 == MD_DIV) || (f3 == MD_REM);
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_ctrl_md_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_ctrl_md_seq_if
// Description : EX-stage bus between the pipeline and the ALU controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_ctrl_md_seq_if #(
    parameter int XLEN   = 32,
    parameter int CTRL_W = 4
);
    logic [1:0]        alu_op;
    logic [2:0]        func3;
    logic [6:0]        func7;
    logic              valid_in;
    logic              flush;
    logic [XLEN-1:0]   op_a;
    logic [XLEN-1:0]   op_b;
    logic [CTRL_W-1:0] alu_ctrl;
    logic              is_md;
    logic              stall;
    logic              md_done;
    logic [XLEN-1:0]   md_result;

    // Pipeline side
    modport master (
        output alu_op, func3, func7, valid_in, flush, op_a, op_b,
        input  alu_ctrl, is_md, stall, md_done, md_result
    );

    // Controller side
    modport slave (
        input  alu_op, func3, func7, valid_in, flush, op_a, op_b,
        output alu_ctrl, is_md, stall, md_done, md_result
    );
endinterface
`default_nettype wire

// File: rtl/alu_ctrl_md_seq_md_iter_unit.sv
`default_nettype none
// ============================================================================
// Module      : alu_ctrl_md_seq_md_iter_unit
// Description : Radix-2 iterative mul/div datapath. Holds the iteration
//               counter, the hi/lo accumulators and the final sign fixup.
//               Also resolves the divide fast paths (x/0, MIN/-1).
// Revision    : 1.0 - initial release
// ============================================================================
module alu_ctrl_md_seq_md_iter_unit
    import alu_ctrl_md_seq_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  wire logic            clk,
    input  wire logic            rst_n,
    input  wire logic            start,
    input  wire logic            step,
    input  wire logic            kill,
    input  wire logic [2:0]      func3,
    input  wire logic [XLEN-1:0] op_a,
    input  wire logic [XLEN-1:0] op_b,
    output logic                 fast,
    output logic                 last,
    output logic [XLEN-1:0]      result
);

    localparam int CNT_W = $clog2(XLEN);

    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_op;
    logic [XLEN-1:0]  r_hi;      // product high half / partial remainder
    logic [XLEN-1:0]  r_lo;      // multiplier bits / dividend-quotient bits
    logic [XLEN-1:0]  r_opnd;    // multiplicand or divisor magnitude
    logic             r_neg_main;
    logic             r_neg_rem;
    logic [XLEN-1:0]  r_result;

    logic             w_is_div;
    logic             w_b_zero;
    logic             w_ovf;
    logic [XLEN-1:0]  w_fast_res;
    logic             w_a_neg;
    logic             w_b_neg;
    logic [XLEN-1:0]  w_mag_a;
    logic [XLEN-1:0]  w_mag_b;
    logic [XLEN:0]    w_sum;
    logic [XLEN:0]    w_shl;
    logic [XLEN:0]    w_diff;
    logic             w_ge;
    logic [XLEN-1:0]  w_nhi;
    logic [XLEN-1:0]  w_nlo;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]  w_quot;
    logic [XLEN-1:0]  w_rem;
    logic [XLEN-1:0]  w_final;

    // Fast-path detection and operand conditioning from the incoming request
    always_comb begin
        w_is_div = func3[2];
        w_b_zero = (op_b == '0);
        w_ovf    = (func3 == MD_DIV || func3 == MD_REM) &&
                   (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);
        if (func3[1])
            w_fast_res = w_b_zero ? op_a : '0;
        else
            w_fast_res = w_b_zero ? '1 : op_a;
        w_a_neg = md_a_signed(func3) & op_a[XLEN-1];
        w_b_neg = md_b_signed(func3) & op_b[XLEN-1];
        w_mag_a = w_a_neg ? (~op_a + 1'b1) : op_a;
        w_mag_b = w_b_neg ? (~op_b + 1'b1) : op_b;
    end

    assign fast   = w_is_div & (w_b_zero | w_ovf);
    assign last   = (r_cnt == CNT_W'(XLEN - 1));
    assign result = r_result;

    // One radix-2 iteration plus the sign fixup applied on the final step
    always_comb begin
        // shift-add multiply: add multiplicand when lsb set, shift right
        w_sum  = {1'b0, r_hi} + ({1'b0, r_opnd} & {(XLEN+1){r_lo[0]}});
        // restoring divide: shift remainder left, trial subtract divisor
        w_shl  = {r_hi, r_lo[XLEN-1]};
        w_diff = w_shl - {1'b0, r_opnd};
        w_ge   = ~w_diff[XLEN];
        if (r_op[2]) begin
            w_nhi = w_ge ? w_diff[XLEN-1:0] : w_shl[XLEN-1:0];
            w_nlo = {r_lo[XLEN-2:0], w_ge};
        end else begin
            w_nhi = w_sum[XLEN:1];
            w_nlo = {w_sum[0], r_lo[XLEN-1:1]};
        end
        w_prod = {w_nhi, w_nlo};
        if (r_neg_main)
            w_prod = ~w_prod + 1'b1;
        w_quot = r_neg_main ? (~w_nlo + 1'b1) : w_nlo;
        w_rem  = r_neg_rem  ? (~w_nhi + 1'b1) : w_nhi;
        if (r_op[2])
            w_final = r_op[1] ? w_rem : w_quot;
        else
            w_final = (r_op[1:0] == 2'b00) ? w_prod[XLEN-1:0]
                                           : w_prod[2*XLEN-1:XLEN];
    end

    // Load on accept, iterate while busy, capture the result on the last step
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt      <= '0;
            r_op       <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_opnd     <= '0;
            r_neg_main <= 1'b0;
            r_neg_rem  <= 1'b0;
            r_result   <= '0;
        end else if (start) begin
            r_cnt      <= '0;
            r_op       <= func3;
            r_hi       <= '0;
            r_lo       <= w_is_div ? w_mag_a : w_mag_b;
            r_opnd     <= w_is_div ? w_mag_b : w_mag_a;
            r_neg_main <= w_a_neg ^ w_b_neg;
            r_neg_rem  <= w_a_neg;
            if (fast)
                r_result <= w_fast_res;
        end else if (kill) begin
            r_cnt <= '0;
        end else if (step) begin
            r_hi  <= w_nhi;
            r_lo  <= w_nlo;
            r_cnt <= r_cnt + 1'b1;
            if (last)
                r_result <= w_final;
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_ctrl_md_seq.sv
`default_nettype none
// ============================================================================
// Module      : alu_ctrl_md_seq
// Description : EX-stage ALU controller. Decodes AluOp/func3/func7 into the
//               single-cycle ALU control word and sequences RV32M ops on the
//               iterative mul/div unit, stalling the pipeline meanwhile.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_ctrl_md_seq
    import alu_ctrl_md_seq_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int CTRL_W   = 4,
    parameter bit ENABLE_M = 1'b1
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    alu_ctrl_md_seq_if.slave  bus
);

    md_state_e  r_state;
    logic       r_done;

    alu_ctrl_e  w_ctrl;
    logic       w_is_md;
    logic       w_accept;
    logic       w_fast;
    logic       w_last;
    logic       w_step;

    // Instruction decode into ALU control and M-op detect
    always_comb begin
        w_ctrl  = ALU_ADD;
        w_is_md = 1'b0;
        case (bus.alu_op)
            C_ALUOP_STORE:  w_ctrl = ALU_ADD;
            C_ALUOP_BRANCH: w_ctrl = ALU_SUB;
            default: begin
                if (bus.alu_op == C_ALUOP_RTYPE && bus.func7 == C_F7_ALT &&
                    bus.func3 == 3'b000) begin
                    w_ctrl = ALU_SUB;
                end else if (bus.alu_op == C_ALUOP_RTYPE && bus.func7 == C_F7_ALT &&
                             bus.func3 == 3'b101) begin
                    w_ctrl = ALU_SRA;
                end else if (bus.alu_op == C_ALUOP_RTYPE && bus.func7 == C_F7_MULDIV &&
                             ENABLE_M) begin
                    w_ctrl  = ALU_ADD;
                    w_is_md = 1'b1;
                end else begin
                    case (bus.func3)
                        3'b000:  w_ctrl = ALU_ADD;
                        3'b001:  w_ctrl = ALU_SLL;
                        3'b010:  w_ctrl = ALU_SLT;
                        3'b011:  w_ctrl = ALU_SLTU;
                        3'b100:  w_ctrl = ALU_XOR;
                        3'b101:  w_ctrl = (bus.alu_op == C_ALUOP_ITYPE && bus.func7[5])
                                          ? ALU_SRA : ALU_SRL;
                        3'b110:  w_ctrl = ALU_OR;
                        default: w_ctrl = ALU_AND;
                    endcase
                end
            end
        endcase
    end

    // Reset gates accept so stall drops as soon as reset asserts
    assign w_accept = rst_n & (r_state == ST_IDLE) & bus.valid_in & w_is_md & ~bus.flush;
    assign w_step   = (r_state == ST_BUSY) & ~bus.flush;

    assign bus.alu_ctrl = CTRL_W'(w_ctrl);
    assign bus.is_md    = w_is_md;
    assign bus.stall    = w_accept | (r_state == ST_BUSY);
    assign bus.md_done  = r_done & ~bus.flush;

    // Sequencer: IDLE -> BUSY (XLEN steps) -> DONE -> IDLE; fast path skips BUSY
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_state <= w_fast ? ST_DONE : ST_BUSY;
                        r_done  <= w_fast;
                    end
                end
                ST_BUSY: begin
                    if (bus.flush) begin
                        r_state <= ST_IDLE;
                    end else if (w_last) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    alu_ctrl_md_seq_md_iter_unit #(
        .XLEN (XLEN)
    ) u_iter (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (w_accept),
        .step   (w_step),
        .kill   (bus.flush),
        .func3  (bus.func3),
        .op_a   (bus.op_a),
        .op_b   (bus.op_b),
        .fast   (w_fast),
        .last   (w_last),
        .result (bus.md_result)
    );

endmodule
`default_nettype wire
